// File: rtl/hamming_rx_deserializer.sv
// Collects a framed serial bit stream (sof marks the MSB) into CW_WIDTH-bit codewords for the Hamming decoder.
// Latency: out_valid rises one clock after the final bit is sampled; one completed word is buffered.
// Backpressure: a word that completes while the buffer is full is dropped and counted; HAMMING_RX_TIMEOUT_EN adds an in-frame idle timeout.
module hamming_rx_deserializer #(
    parameter int CW_WIDTH       = 105,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 sof,
    output logic [CW_WIDTH-1:0]  out_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] ovf_cnt,
    output logic [CNT_WIDTH-1:0] abort_cnt,
    input  logic                 clear_stats
);

    localparam int BW = $clog2(CW_WIDTH + 1);

    if (CW_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("hamming_rx_deserializer: CW_WIDTH and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW_WIDTH-1:0]   r_shreg, w_shreg_nxt;
    logic [BW-1:0]         r_count, w_count_nxt;
    logic [CW_WIDTH-1:0]   r_out_word;
    logic                  r_out_valid;
    logic [CNT_WIDTH-1:0]  r_ovf_cnt, r_abort_cnt;
    logic                  w_complete, w_abort, w_buf_free, w_ovf, w_timeout;

`ifdef HAMMING_RX_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] r_gap;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle; a bit on that cycle wins.
    assign w_timeout = (r_state == S_COLLECT) && !bit_valid && (r_gap == GW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_gap <= '0;
        else if (r_state != S_COLLECT || bit_valid || w_timeout)
            r_gap <= '0;
        else
            r_gap <= r_gap + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_count_nxt = r_count;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        if (bit_valid && (sof || r_state == S_COLLECT)) begin
            if (sof) begin
                w_abort        = (r_state == S_COLLECT);
                w_shreg_nxt    = '0;
                w_shreg_nxt[0] = bit_in;
                w_count_nxt    = BW'(1);
            end else begin
                w_shreg_nxt    = r_shreg << 1;
                w_shreg_nxt[0] = bit_in;
                w_count_nxt    = r_count + 1'b1;
            end
            w_state_nxt = S_COLLECT;
            if (w_count_nxt == BW'(CW_WIDTH)) begin
                w_complete  = 1'b1;
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        end else if (w_timeout) begin
            w_abort     = 1'b1;
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_count <= w_count_nxt;
        end
    end

    // The buffer can take a new word if empty or being drained this very cycle.
    assign w_buf_free = !r_out_valid || out_ready;
    assign w_ovf      = w_complete && !w_buf_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_complete && w_buf_free) begin
            r_out_word  <= w_shreg_nxt;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt   <= '0;
            r_abort_cnt <= '0;
        end else if (clear_stats) begin
            r_ovf_cnt   <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (w_ovf && r_ovf_cnt != '1)
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            if (w_abort && r_abort_cnt != '1)
                r_abort_cnt <= r_abort_cnt + 1'b1;
        end
    end

    assign out_word  = r_out_word;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == S_COLLECT);
    assign ovf_cnt   = r_ovf_cnt;
    assign abort_cnt = r_abort_cnt;

endmodule
